// File: rtl/mc_ctrl_exec.sv
// Multi-cycle MIPS control and execute block: Moore control FSM, 32-bit ALU
// and little-endian store byte-enable generator.
module mc_ctrl_exec #(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Op,
    input  logic [4:0]  Rt,
    input  logic [5:0]  Funct,
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    input  logic [1:0]  addr_lo,
    output logic [31:0] ALU_result,
    output logic        Zero,
    output logic [3:0]  be,
    output logic [1:0]  RegDst,
    output logic [1:0]  ALUSrcA,
    output logic [2:0]  ALUSrcB,
    output logic [1:0]  MemtoReg,
    output logic [2:0]  PCSource,
    output logic [2:0]  LoadType,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Reverse
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] EXEC_R = 4'd2;
    localparam logic [3:0] WB_R   = 4'd3;
    localparam logic [3:0] JR     = 4'd4;
    localparam logic [3:0] EXEC_I = 4'd5;
    localparam logic [3:0] WB_I   = 4'd6;
    localparam logic [3:0] MEMADR = 4'd7;
    localparam logic [3:0] MEMRD  = 4'd8;
    localparam logic [3:0] MEMWB  = 4'd9;
    localparam logic [3:0] MEMWR  = 4'd10;
    localparam logic [3:0] BRANCH = 4'd11;
    localparam logic [3:0] JUMP   = 4'd12;
    localparam logic [3:0] EXC    = 4'd13;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_SLTZ = 4'd12;

    // The exception vector is muxed in by the datapath; only its alignment matters here.
    if (EXC_VECTOR[1:0] != 2'b00) begin : g_exc_vector_check
        $error("EXC_VECTOR must be word aligned");
    end

    logic [3:0] state;
    logic [3:0] state_next;
    logic [3:0] alu_op;
    logic [3:0] r_op;
    logic       r_valid;
    logic       r_shift;
    logic [3:0] i_op;
    logic       i_zext;
    logic       is_load;
    logic [2:0] load_type;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        r_valid = 1'b1;
        r_shift = 1'b0;
        r_op    = ALU_ADD;
        case (Funct)
            6'h20, 6'h21: r_op = ALU_ADD;
            6'h22, 6'h23: r_op = ALU_SUB;
            6'h24:        r_op = ALU_AND;
            6'h25:        r_op = ALU_OR;
            6'h26:        r_op = ALU_XOR;
            6'h27:        r_op = ALU_NOR;
            6'h2A:        r_op = ALU_SLT;
            6'h2B:        r_op = ALU_SLTU;
            6'h00: begin r_op = ALU_SLL; r_shift = 1'b1; end
            6'h02: begin r_op = ALU_SRL; r_shift = 1'b1; end
            6'h03: begin r_op = ALU_SRA; r_shift = 1'b1; end
            default:      r_valid = 1'b0;
        endcase

        i_op   = ALU_ADD;
        i_zext = 1'b0;
        case (Op)
            6'h0A:   i_op = ALU_SLT;
            6'h0B:   i_op = ALU_SLTU;
            6'h0C: begin i_op = ALU_AND; i_zext = 1'b1; end
            6'h0D: begin i_op = ALU_OR;  i_zext = 1'b1; end
            6'h0E: begin i_op = ALU_XOR; i_zext = 1'b1; end
            6'h0F: begin i_op = ALU_LUI; i_zext = 1'b1; end
            default: i_op = ALU_ADD;
        endcase

        is_load   = 1'b1;
        load_type = 3'd0;
        case (Op)
            6'h23:   load_type = 3'd0;
            6'h21:   load_type = 3'd1;
            6'h25:   load_type = 3'd2;
            6'h20:   load_type = 3'd3;
            6'h24:   load_type = 3'd4;
            default: is_load   = 1'b0;
        endcase
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (Op)
                    6'h00: begin
                        if (Funct == 6'h08 || Funct == 6'h09) state_next = JR;
                        else if (r_valid)                     state_next = EXEC_R;
                        else                                  state_next = EXC;
                    end
                    6'h01:        state_next = (Rt == 5'd0 || Rt == 5'd1) ? BRANCH : EXC;
                    6'h02, 6'h03: state_next = JUMP;
                    6'h04, 6'h05: state_next = BRANCH;
                    6'h08, 6'h09, 6'h0A, 6'h0B,
                    6'h0C, 6'h0D, 6'h0E, 6'h0F: state_next = EXEC_I;
                    6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
                    6'h28, 6'h29, 6'h2B: state_next = MEMADR;
                    default:      state_next = EXC;
                endcase
            end
            EXEC_R: state_next = WB_R;
            EXEC_I: state_next = WB_I;
            MEMADR: state_next = is_load ? MEMRD : MEMWR;
            MEMRD:  state_next = MEMWB;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        RegDst      = 2'd0;
        ALUSrcA     = 2'd0;
        ALUSrcB     = 3'd0;
        MemtoReg    = 2'd0;
        PCSource    = 3'd0;
        LoadType    = 3'd0;
        RegWrite    = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        Reverse     = 1'b0;
        alu_op      = ALU_ADD;
        case (state)
            FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 3'd1;
            end
            DECODE: ALUSrcB = 3'd3;
            EXEC_R, WB_R: begin
                ALUSrcA = r_shift ? 2'd2 : 2'd1;
                alu_op  = r_op;
                if (state == WB_R) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'd1;
                end
            end
            JR: begin
                PCWrite  = 1'b1;
                PCSource = 3'd4;
                if (Funct == 6'h09) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'd1;
                    MemtoReg = 2'd2;
                end
            end
            EXEC_I, WB_I: begin
                ALUSrcA  = 2'd1;
                ALUSrcB  = i_zext ? 3'd4 : 3'd2;
                alu_op   = i_op;
                RegWrite = (state == WB_I);
            end
            MEMADR, MEMRD, MEMWB, MEMWR: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 3'd2;
                if (state == MEMWB) begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'd1;
                    LoadType = load_type;
                end
                MemWrite = (state == MEMWR);
            end
            BRANCH: begin
                ALUSrcA     = 2'd1;
                PCWriteCond = 1'b1;
                PCSource    = 3'd1;
                // REGIMM compares sign only: Zero set means src0 >= 0.
                if (Op == 6'h01) begin
                    alu_op  = ALU_SLTZ;
                    Reverse = (Rt == 5'd0);
                end else begin
                    alu_op  = ALU_SUB;
                    Reverse = (Op == 6'h05);
                end
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 3'd2;
                if (Op == 6'h03) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'd2;
                    MemtoReg = 2'd2;
                end
            end
            EXC: begin
                PCWrite  = 1'b1;
                PCSource = 3'd3;
            end
            default: alu_op = ALU_ADD;
        endcase

        if (!reset) begin
            RegWrite    = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
        end
    end

    always_comb begin
        case (alu_op)
            ALU_ADD:  ALU_result = src0 + src1;
            ALU_SUB:  ALU_result = src0 - src1;
            ALU_AND:  ALU_result = src0 & src1;
            ALU_OR:   ALU_result = src0 | src1;
            ALU_XOR:  ALU_result = src0 ^ src1;
            ALU_NOR:  ALU_result = ~(src0 | src1);
            ALU_SLT:  ALU_result = {31'b0, $signed(src0) < $signed(src1)};
            ALU_SLTU: ALU_result = {31'b0, src0 < src1};
            ALU_SLL:  ALU_result = src1 << src0[4:0];
            ALU_SRL:  ALU_result = src1 >> src0[4:0];
            ALU_SRA:  ALU_result = $unsigned($signed(src1) >>> src0[4:0]);
            ALU_LUI:  ALU_result = {src1[15:0], 16'h0000};
            ALU_SLTZ: ALU_result = {31'b0, src0[31]};
            default:  ALU_result = '0;
        endcase
    end

    assign Zero = (ALU_result == '0);

    always_comb begin
        case (Op)
            6'h29:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
            6'h28:   be = 4'b0001 << addr_lo;
            default: be = '1;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_exec.sv
// Self-checking bench for mc_ctrl_exec: directed instructions plus random
// instruction/operand streams checked against an instruction-level model.
module tb_mc_ctrl_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Op;
    logic [4:0]  Rt;
    logic [5:0]  Funct;
    logic [31:0] src0, src1;
    logic [1:0]  addr_lo;
    logic [31:0] ALU_result;
    logic        Zero;
    logic [3:0]  be;
    logic [1:0]  RegDst, ALUSrcA, MemtoReg;
    logic [2:0]  ALUSrcB, PCSource, LoadType;
    logic        RegWrite, MemWrite, IRWrite, PCWrite, PCWriteCond, Reverse;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mc_ctrl_exec #(.EXC_VECTOR(32'h8000_0180)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Rt(Rt), .Funct(Funct),
        .src0(src0), .src1(src1), .addr_lo(addr_lo),
        .ALU_result(ALU_result), .Zero(Zero), .be(be),
        .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .MemtoReg(MemtoReg), .PCSource(PCSource), .LoadType(LoadType),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Reverse(Reverse)
    );

    typedef struct packed {
        logic [1:0] reg_dst;
        logic [1:0] src_a;
        logic [2:0] src_b;
        logic [1:0] mem_to_reg;
        logic [2:0] pc_src;
        logic [2:0] load_type;
        logic       reg_write;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reverse;
    } ctrl_t;

    ctrl_t obs;
    always_comb obs = {RegDst, ALUSrcA, ALUSrcB, MemtoReg, PCSource, LoadType,
                       RegWrite, MemWrite, IRWrite, PCWrite, PCWriteCond, Reverse};

    localparam int C_R = 0, C_SH = 1, C_JR = 2, C_JALR = 3, C_I = 4, C_LD = 5,
                   C_ST = 6, C_BR = 7, C_J = 8, C_JAL = 9, C_EXC = 10;

    logic [5:0] op_tab [24] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    logic [5:0] fn_tab [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};

    function automatic int classify(logic [5:0] op, logic [5:0] fn, logic [4:0] rt);
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: return C_R;
                    6'h00, 6'h02, 6'h03:        return C_SH;
                    6'h08:                      return C_JR;
                    6'h09:                      return C_JALR;
                    default:                    return C_EXC;
                endcase
            end
            6'h01:                       return (rt <= 5'd1) ? C_BR : C_EXC;
            6'h02:                       return C_J;
            6'h03:                       return C_JAL;
            6'h04, 6'h05:                return C_BR;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F:  return C_I;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: return C_LD;
            6'h28, 6'h29, 6'h2B:         return C_ST;
            default:                     return C_EXC;
        endcase
    endfunction

    function automatic int latency(int c);
        if (c == C_LD) return 5;
        if (c == C_R || c == C_SH || c == C_I || c == C_ST) return 4;
        return 3;
    endfunction

    function automatic ctrl_t exp_ctrl(logic [5:0] op, logic [5:0] fn, logic [4:0] rt, int step);
        ctrl_t e;
        int c;
        e = '0;
        c = classify(op, fn, rt);
        if (step == 0) begin
            e.ir_write = 1'b1; e.pc_write = 1'b1; e.src_b = 3'd1;
        end else if (step == 1) begin
            e.src_b = 3'd3;
        end else begin
            case (c)
                C_R, C_SH: begin
                    e.src_a = (c == C_SH) ? 2'd2 : 2'd1;
                    if (step == 3) begin e.reg_write = 1'b1; e.reg_dst = 2'd1; end
                end
                C_JR, C_JALR: begin
                    e.pc_write = 1'b1; e.pc_src = 3'd4;
                    if (c == C_JALR) begin e.reg_write = 1'b1; e.reg_dst = 2'd1; e.mem_to_reg = 2'd2; end
                end
                C_I: begin
                    e.src_a = 2'd1;
                    e.src_b = (op >= 6'h0C) ? 3'd4 : 3'd2;
                    e.reg_write = (step == 3);
                end
                C_LD: begin
                    e.src_a = 2'd1; e.src_b = 3'd2;
                    if (step == 4) begin
                        e.reg_write = 1'b1; e.mem_to_reg = 2'd1;
                        case (op)
                            6'h21:   e.load_type = 3'd1;
                            6'h25:   e.load_type = 3'd2;
                            6'h20:   e.load_type = 3'd3;
                            6'h24:   e.load_type = 3'd4;
                            default: e.load_type = 3'd0;
                        endcase
                    end
                end
                C_ST: begin
                    e.src_a = 2'd1; e.src_b = 3'd2;
                    e.mem_write = (step == 3);
                end
                C_BR: begin
                    e.src_a = 2'd1; e.pc_write_cond = 1'b1; e.pc_src = 3'd1;
                    e.reverse = (op == 6'h05) || (op == 6'h01 && rt == 5'd0);
                end
                C_J, C_JAL: begin
                    e.pc_write = 1'b1; e.pc_src = 3'd2;
                    if (c == C_JAL) begin e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; end
                end
                default: begin
                    e.pc_write = 1'b1; e.pc_src = 3'd3;
                end
            endcase
        end
        return e;
    endfunction

    function automatic bit alu_defined(int c, int step);
        return step < 2 || !(c inside {C_JR, C_JALR, C_J, C_JAL, C_EXC});
    endfunction

    function automatic logic [31:0] exp_alu(logic [5:0] op, logic [5:0] fn, int c, int step,
                                            logic [31:0] a, logic [31:0] b);
        logic [63:0] ext;
        if (step < 2 || c == C_LD || c == C_ST) return a + b;
        if (c == C_BR) return (op == 6'h01) ? ((int'(a) < 0) ? 32'd1 : 32'd0) : a - b;
        if (c == C_I) begin
            case (op)
                6'h0A:   return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                6'h0B:   return (a < b) ? 32'd1 : 32'd0;
                6'h0C:   return a & b;
                6'h0D:   return a | b;
                6'h0E:   return a ^ b;
                6'h0F:   return {b[15:0], 16'h0000};
                default: return a + b;
            endcase
        end
        case (fn)
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24:        return a & b;
            6'h25:        return a | b;
            6'h26:        return a ^ b;
            6'h27:        return ~(a | b);
            6'h2A:        return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6'h2B:        return (a < b) ? 32'd1 : 32'd0;
            6'h00:        return b << a[4:0];
            6'h02:        return b >> a[4:0];
            default: begin
                ext = {{32{b[31]}}, b} >> a[4:0];
                return ext[31:0];
            end
        endcase
    endfunction

    function automatic logic [3:0] exp_be(logic [5:0] op, logic [1:0] lo);
        if (op == 6'h29) return lo[1] ? 4'b1100 : 4'b0011;
        if (op == 6'h28) begin
            case (lo)
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        return 4'b1111;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Runs one instruction from FETCH; abort_step >= 0 pulls reset low in that cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                             input bit rnd, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] lo, input int abort_step);
        int c;
        int lat;
        ctrl_t e;
        c   = classify(op, fn, rt);
        lat = latency(c);
        Op = op; Funct = fn; Rt = rt;
        for (int s = 0; s < lat; s++) begin
            if (rnd) begin
                src0 = $urandom; src1 = $urandom; addr_lo = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) src1 = src0;
            end else begin
                src0 = a; src1 = b; addr_lo = lo;
            end
            if (s == abort_step) reset = 1'b0;
            @(negedge clk);
            e = exp_ctrl(op, fn, rt, s);
            if (s == abort_step) begin
                e.reg_write = 1'b0; e.mem_write = 1'b0; e.ir_write = 1'b0;
                e.pc_write = 1'b0; e.pc_write_cond = 1'b0;
            end
            chk($sformatf("ctrl op=%02h fn=%02h rt=%0d step=%0d", op, fn, rt, s), 32'(obs), 32'(e));
            if (alu_defined(c, s)) begin
                chk($sformatf("alu op=%02h fn=%02h step=%0d a=%h b=%h", op, fn, s, src0, src1),
                    ALU_result, exp_alu(op, fn, c, s, src0, src1));
                chk($sformatf("zero op=%02h fn=%02h step=%0d", op, fn, s),
                    32'(Zero), 32'(exp_alu(op, fn, c, s, src0, src1) == 32'd0));
            end
            chk($sformatf("be op=%02h lo=%0d", op, addr_lo), 32'(be), 32'(exp_be(op, addr_lo)));
            @(posedge clk); #1;
            if (s == abort_step) begin
                reset = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int k, abort;
        logic [5:0] rop, rfn;
        logic [4:0] rrt;
        reset = 1'b0; Op = 6'h23; Rt = '0; Funct = '0;
        src0 = '0; src1 = '0; addr_lo = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("reset enables cycle %0d", i),
                32'({RegWrite, MemWrite, IRWrite, PCWrite, PCWriteCond}), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;

        run_instr(6'h00, 6'h21, 5'd0, 1'b0, 32'd5, 32'd7, 2'd0, -1);
        chk("addu result", ALU_result, 32'd12);
        run_instr(6'h20, 6'h00, 5'd0, 1'b0, 32'h100, 32'd6, 2'd2, -1);
        run_instr(6'h28, 6'h00, 5'd0, 1'b0, 32'h100, 32'd6, 2'd2, -1);
        run_instr(6'h05, 6'h00, 5'd0, 1'b0, 32'd9, 32'd9, 2'd0, -1);
        run_instr(6'h01, 6'h00, 5'd0, 1'b0, 32'hFFFF_FFF0, 32'd0, 2'd0, -1);
        run_instr(6'h01, 6'h00, 5'd1, 1'b0, 32'h0000_0010, 32'd0, 2'd0, -1);
        run_instr(6'h04, 6'h00, 5'd0, 1'b0, 32'd3, 32'd3, 2'd0, -1);
        run_instr(6'h03, 6'h00, 5'd0, 1'b0, 32'd0, 32'd0, 2'd0, -1);
        run_instr(6'h3F, 6'h00, 5'd0, 1'b0, 32'd1, 32'd2, 2'd0, -1);
        run_instr(6'h00, 6'h03, 5'd0, 1'b0, 32'd4, 32'h8000_0000, 2'd0, -1);
        run_instr(6'h0A, 6'h00, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 2'd0, -1);
        run_instr(6'h0B, 6'h00, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 2'd0, -1);
        run_instr(6'h0F, 6'h00, 5'd0, 1'b0, 32'd0, 32'h0000_1234, 2'd0, -1);
        run_instr(6'h29, 6'h00, 5'd0, 1'b0, 32'd0, 32'd0, 2'd3, -1);
        run_instr(6'h00, 6'h09, 5'd0, 1'b0, 32'h40, 32'd0, 2'd0, -1);
        run_instr(6'h01, 6'h00, 5'd2, 1'b0, 32'd0, 32'd0, 2'd0, -1);
        run_instr(6'h2B, 6'h00, 5'd0, 1'b0, 32'h200, 32'd8, 2'd1, 3);
        run_instr(6'h23, 6'h00, 5'd0, 1'b0, 32'h200, 32'd8, 2'd0, 4);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                rop = 6'($urandom); rfn = 6'($urandom); rrt = 5'($urandom);
            end else begin
                k = int'($urandom_range(0, 23));
                rop = op_tab[k];
                k = int'($urandom_range(0, 15));
                rfn = (k < 13) ? fn_tab[k] : ((k == 13) ? 6'h08 : ((k == 14) ? 6'h09 : 6'($urandom)));
                rrt = 5'($urandom_range(0, 2));
            end
            abort = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 2)) : -1;
            run_instr(rop, rfn, rrt, 1'b1, 32'd0, 32'd0, 2'd0, abort);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_exec.md
Name: mc_ctrl_exec

Overview:
- Multi-cycle MIPS control-and-execute block: Moore control FSM, 32-bit ALU, and store byte-enable generator.
- Sits between the instruction register and the datapath muxes/flops (PC, register file, A/B, ALUOut, data memory, MDR).
- ALU opcode and store type are internal.

Parameters:
- EXC_VECTOR, 32'h8000_0180, exception PC. It is selected externally via PCSource=3; recorded here for documentation.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- Op  in  6  instr[31:26]
- Rt  in  5  instr[20:16]
- Funct  in  6  instr[5:0]
- src0  in  32  ALU operand A (PC / A / shamt)
- src1  in  32  ALU operand B (B / 4 / sext / sext<<2 / zext)
- addr_lo  in  2  ALUOut[1:0]
- ALU_result  out  32  combinational ALU result
- Zero  out  1  ALU_result==0
- be  out  4  store byte enables
- RegDst  out  2  0 rt, 1 rd, 2 r31
- ALUSrcA  out  2  0 PC, 1 A, 2 shamt
- ALUSrcB  out  3  0 B, 1 const 4, 2 sext, 3 sext<<2, 4 zext
- MemtoReg  out  2  0 ALUOut, 1 load data, 2 PC
- PCSource  out  3  0 ALU_result, 1 ALUOut, 2 jump target, 3 exception vector, 4 A
- LoadType  out  3  0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu
- RegWrite, MemWrite, IRWrite, PCWrite, PCWriteCond, Reverse  out  1 each  enables/flags

Behaviour:
- Datapath contract: next-PC write = PCWrite | (PCWriteCond & (Zero ^ Reverse)). A, B, ALUOut and MDR load every cycle.
- Reset: when reset==0 at a clk edge, state<=FETCH. While reset==0, RegWrite, MemWrite, IRWrite, PCWrite and PCWriteCond are forced 0.
- Outputs are combinational from state plus Op/Funct/Rt. Unlisted outputs are 0.
- Write-enables are also 0 in any state not listed as asserting them.
- ALU ops (src0 op src1):
  - ADD, SUB: wrapping, no overflow trap.
  - AND, OR, XOR, NOR.
  - SLT (signed), SLTU: result {31'b0, flag}.
  - SLL, SRL, SRA: src1 shifted by src0[4:0].
  - LUI: src1<<16.
  - SLTZ: {31'b0, src0[31]}.
- FSM states and transitions:
  - FETCH: IRWrite, PCWrite, ALUSrcA=0, ALUSrcB=1, ADD, PCSource=0. Next: DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=3, ADD (branch target into ALUOut). Next chosen by Op.
  - EXEC_R: ALUSrcA=1 (2 for sll/srl/sra), ALUSrcB=0, op from Funct. Next: WB_R.
    - Funct: 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU, 00 SLL, 02 SRL, 03 SRA.
  - WB_R: EXEC_R controls held; RegWrite, RegDst=1, MemtoReg=0. Next: FETCH.
  - JR (Funct 08): PCWrite, PCSource=4. JALR (Funct 09) additionally asserts RegWrite, RegDst=1, MemtoReg=2. Next: FETCH.
  - EXEC_I: ALUSrcA=1. Next: WB_I.
    - addi/addiu (08/09): ALUSrcB=2, ADD.
    - slti/sltiu (0A/0B): ALUSrcB=2, SLT/SLTU.
    - andi/ori/xori (0C/0D/0E): ALUSrcB=4, AND/OR/XOR.
    - lui (0F): ALUSrcB=4, LUI.
  - WB_I: EXEC_I controls held; RegWrite, RegDst=0, MemtoReg=0. Next: FETCH.
  - MEMADR: ALUSrcA=1, ALUSrcB=2, ADD. MEMRD, MEMWB and MEMWR keep these settings so ALUOut stays stable.
    - Loads 23/21/25/20/24 (lw/lh/lhu/lb/lbu) -> MEMRD -> MEMWB (RegWrite, RegDst=0, MemtoReg=1, LoadType per Op).
    - Stores 2B/29/28 (sw/sh/sb) -> MEMWR (MemWrite). Next: FETCH.
  - BRANCH: ALUSrcA=1, PCWriteCond, PCSource=1. Next: FETCH.
    - beq (04): ALUSrcB=0, SUB, Reverse=0.
    - bne (05): ALUSrcB=0, SUB, Reverse=1.
    - REGIMM (01): SLTZ; Rt=01 bgez Reverse=0, Rt=00 bltz Reverse=1.
  - JUMP: PCWrite, PCSource=2. j (02); jal (03) additionally asserts RegWrite, RegDst=2, MemtoReg=2. Next: FETCH.
  - EXC: any undefined Op/Funct/Rt. PCWrite, PCSource=3. Next: FETCH.
- BE (little-endian):
  - sw: 1111.
  - sh: addr_lo[1] ? 1100 : 0011 (addr_lo[0] ignored).
  - sb: 0001 << addr_lo.
  - Non-store instructions: 1111.
- Instruction latencies: R/I 4 cycles, loads 5, stores 4, branch/jump/exception 3.
- A reset asserted in any state aborts the instruction at that edge; there is no partial memory or register write.

Test Plan:
- Hold reset=0 two cycles, then release -> all enables 0 during reset; first cycle after release shows IRWrite=1, PCWrite=1, ALUSrcB=1.
- addu (Op 00, Funct 21), src0=5, src1=7 -> ALU_result=12, Zero=0; WB_R asserts RegWrite, RegDst=1; 4-cycle sequence.
- lb at addr_lo=2 -> 5-cycle sequence; MEMWB: LoadType=3, MemtoReg=1. sb at addr_lo=2 -> be=0100, MemWrite=1 in cycle 4 only.
- bne with src0=src1=9 -> ALU_result=0, Zero=1, Reverse=1, PCWriteCond=1 (branch not taken). bltz with src0=32'hFFFFFFF0 -> ALU_result=1, Reverse=1 (taken).
- jal -> JUMP state: PCWrite, PCSource=2, RegDst=2, MemtoReg=2, RegWrite.
- Op 3F -> EXC state: PCSource=3, PCWrite=1, then FETCH.
